// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/sub split into STAGES slices, one slice per stage.
// Ports: clk, rst_n, in_valid/in_ready/a/b/c_in/sub in; out_valid/out_ready/sum/c_out/overflow out.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int S = WIDTH / STAGES;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a multiple of STAGES");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Single global enable: the whole pipe moves or the whole pipe holds.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // Subtract is A + ~B + 1; the caller's carry-in is dropped.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | c_in;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int SW = (k + 1) * S;

    logic [S-1:0]  op_a;
    logic [S-1:0]  op_b;
    logic          c_i;
    logic [S:0]    r;
    logic [SW-1:0] s_d;
    logic [SW-1:0] s_q;
    logic          c_q;
    logic          v_d;
    logic          v_q;

    if (k == 0) begin : g_head
      assign op_a = a[S-1:0];
      assign op_b = b_eff[S-1:0];
      assign c_i  = cin_eff;
      assign v_d  = in_valid & adv;
      assign s_d  = r[S-1:0];
    end else begin : g_tail
      assign op_a = g_st[k-1].g_skew.a_q[S-1:0];
      assign op_b = g_st[k-1].g_skew.b_q[S-1:0];
      assign c_i  = g_st[k-1].c_q;
      assign v_d  = g_st[k-1].v_q;
      // New slice lands on top of the already-resolved low slices.
      assign s_d  = {r[S-1:0], g_st[k-1].s_q};
    end

    assign r = {1'b0, op_a} + {1'b0, op_b} + {{S{1'b0}}, c_i};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (adv) begin
        s_q <= s_d;
        c_q <= r[S];
        v_q <= v_d;
      end
    end

    // Operand slices not yet consumed, kept right-aligned so the
    // next stage always takes the low S bits.
    if (k < STAGES - 1) begin : g_skew
      localparam int AW = WIDTH - SW;

      logic [AW-1:0] a_d;
      logic [AW-1:0] b_d;
      logic [AW-1:0] a_q;
      logic [AW-1:0] b_q;

      if (k == 0) begin : g_src
        assign a_d = a[WIDTH-1:S];
        assign b_d = b_eff[WIDTH-1:S];
      end else begin : g_src
        assign a_d = g_st[k-1].g_skew.a_q[AW+S-1:S];
        assign b_d = g_st[k-1].g_skew.b_q[AW+S-1:S];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    if (k == STAGES - 1) begin : g_ovf
      logic ov_d;
      logic ov_q;

      // Carry into the MSB recovered from the MSB sum bit.
      assign ov_d = (op_a[S-1] ^ op_b[S-1] ^ r[S-1]) ^ r[S];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ov_q <= 1'b0;
        end else if (adv) begin
          ov_q <= ov_d;
        end
      end
    end
  end

  assign sum       = g_st[STAGES-1].s_q;
  assign c_out     = g_st[STAGES-1].c_q;
  assign out_valid = g_st[STAGES-1].v_q;
  assign overflow  = g_st[STAGES-1].g_ovf.ov_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: scoreboard bench, directed tests on (32,4)
// plus random regression on (32,4), (32,1), (8,8), (64,2).
`timescale 1ns/1ps
module tb_pipelined_adder;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ov;
  } exp_t;

  int n_pass  = 0;
  int n_total = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;
  logic rr_n  = 1'b1;

  task automatic chk(input string nm, input logic [65:0] act,
                     input logic [65:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h at %0t", nm, act, req, $time);
  endtask

  // Reference: plain integer arithmetic on unsigned and signed values.
  function automatic exp_t model(input int w, input logic [63:0] a,
                                 input logic [63:0] b, input logic cin,
                                 input logic sub);
    exp_t e;
    logic signed [67:0] full, m, ua, ub, sa, sb, r, u, hi, lo;
    full = 68'sd1 <<< w;
    m    = full - 68'sd1;
    ua   = $signed({4'b0, a}) & m;
    ub   = $signed({4'b0, b}) & m;
    sa   = a[w-1] ? ua - full : ua;
    sb   = b[w-1] ? ub - full : ub;
    if (sub) begin
      r      = sa - sb;
      u      = (ua - ub) & m;
      e.cout = (ua >= ub);
    end else begin
      r      = sa + sb + $signed({67'b0, cin});
      u      = ua + ub + $signed({67'b0, cin});
      e.cout = (u >= full);
      u      = u & m;
    end
    e.sum = u[63:0];
    hi    = (full >>> 1) - 68'sd1;
    lo    = -(full >>> 1);
    e.ov  = (r > hi) || (r < lo);
    return e;
  endfunction

  function automatic exp_t mk(input logic [31:0] s, input logic c,
                              input logic o);
    exp_t e;
    e.sum  = {32'h0, s};
    e.cout = c;
    e.ov   = o;
    return e;
  endfunction

  // ---------------- main (32,4) instance ----------------
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [31:0] a = '0, b = '0, sum;
  logic        c_in = 1'b0, sub = 1'b0, c_out, overflow;

  pipelined_adder #(.WIDTH(32), .STAGES(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .overflow(overflow)
  );

  exp_t q0[$];

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        if (q0.size() == 0) begin
          chk("main_unexpected_beat", 66'd1, 66'd0);
        end else begin
          e = q0.pop_front();
          chk("main_result", {32'h0, sum, c_out, overflow},
              {e.sum, e.cout, e.ov});
        end
      end
    end
  end

  task automatic put(input logic [31:0] ta, input logic [31:0] tb2,
                     input logic tc, input logic ts);
    int n = 0;
    @(negedge clk);
    a = ta; b = tb2; c_in = tc; sub = ts; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) chk("put_timeout", 66'd1, 66'd0);
  endtask

  task automatic drain0();
    int n = 0;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (q0.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_main", 66'(q0.size()), 66'd0);
  endtask

  logic [31:0] ca [7] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd5, 32'h1234_5678,
                          32'hFFFF_FFFF, 32'h0, 32'h8000_0000};
  logic [31:0] cb [7] = '{32'h0, 32'h1, 32'd7, 32'h1234_5678,
                          32'h1, 32'h1, 32'h1};
  logic        cc [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic        cs [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [31:0] es [7] = '{32'h0, 32'h8000_0000, 32'hFFFF_FFFE, 32'h0,
                          32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
  logic        ec [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic        eo [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  // ---------------- random regression instances ----------------
  for (genvar g = 0; g < 4; g++) begin : g_rnd
    localparam int W = (g == 2) ? 8 : (g == 3) ? 64 : 32;
    localparam int N = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 8 : 2;

    logic         r_iv = 1'b0, r_ir, r_ov, r_or = 1'b0;
    logic [W-1:0] r_a = '0, r_b = '0, r_s;
    logic         r_ci = 1'b0, r_sb = 1'b0, r_co, r_of;
    bit           done = 1'b0;
    exp_t         q[$];

    pipelined_adder #(.WIDTH(W), .STAGES(N)) u_rnd (
      .clk(clk), .rst_n(rr_n),
      .in_valid(r_iv), .in_ready(r_ir),
      .a(r_a), .b(r_b), .c_in(r_ci), .sub(r_sb),
      .out_valid(r_ov), .out_ready(r_or),
      .sum(r_s), .c_out(r_co), .overflow(r_of)
    );

    function automatic logic [63:0] pick();
      logic [63:0] v;
      v = {$urandom, $urandom};
      case ($urandom_range(0, 15))
        0: v = '0;
        1: v = '1;
        2: v = 64'h1 << (W - 1);
        3: v = (64'h1 << (W - 1)) - 64'h1;
        default: ;
      endcase
      return v;
    endfunction

    initial begin
      logic [63:0] ta, tb2;
      int sent = 0;
      int cyc  = 0;
      int n    = 0;
      @(negedge clk);
      wait (rr_n === 1'b1);
      while (sent < 1000 && cyc < 20000) begin
        @(negedge clk);
        ta   = pick();
        tb2  = pick();
        r_a  = ta[W-1:0];
        r_b  = tb2[W-1:0];
        r_ci = 1'($urandom_range(0, 1));
        r_sb = 1'($urandom_range(0, 1));
        r_iv = ($urandom_range(0, 9) < 7);
        r_or = ($urandom_range(0, 9) < 7);
        #1;
        if (r_iv && r_ir) begin
          q.push_back(model(W, ta, tb2, r_ci, r_sb));
          sent++;
        end
        cyc++;
      end
      chk($sformatf("rnd%0d_sent", g), 66'(sent), 66'd1000);
      @(negedge clk);
      r_iv = 1'b0;
      r_or = 1'b1;
      while (q.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("rnd%0d_drain", g), 66'(q.size()), 66'd0);
      done = 1'b1;
    end

    initial begin
      exp_t e;
      forever begin
        @(negedge clk);
        #2;
        if (rr_n && r_ov && r_or) begin
          if (q.size() == 0) begin
            chk($sformatf("rnd%0d_unexpected", g), 66'd1, 66'd0);
          end else begin
            e = q.pop_front();
            chk($sformatf("rnd%0d_result", g),
                {64'(r_s), r_co, r_of}, {e.sum, e.cout, e.ov});
          end
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [5:0]  pat;
    logic [35:0] held;
    int          sent, t, vcnt, n;

    #1;
    rst_n = 1'b0;
    rr_n  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("reset_state", {out_valid, in_ready, c_out, overflow, sum},
          {1'b0, 1'b1, 1'b0, 1'b0, 32'h0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    rr_n  = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("idle_after_reset", {out_valid, in_ready, c_out, overflow, sum},
          {1'b0, 1'b1, 1'b0, 1'b0, 32'h0});
    end

    // Latency: accepted at edge N, valid for exactly the cycle after N+3.
    put(32'h0000_FFFF, 32'h1, 1'b0, 1'b0);
    q0.push_back(mk(32'h0001_0000, 1'b0, 1'b0));
    pat = '0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) in_valid = 1'b0;
      #1;
      pat[i-1] = out_valid;
    end
    chk("latency_pattern", 66'(pat), 66'b001000);

    // Arithmetic corners, back to back.
    for (int i = 0; i < 7; i++) begin
      put(ca[i], cb[i], cc[i], cs[i]);
      q0.push_back(mk(es[i], ec[i], eo[i]));
    end
    drain0();

    // Backpressure: 16 beats, out_ready low for t = 8..12.
    sent = 0;
    t    = 0;
    held = '0;
    while (sent < 16 && t < 100) begin
      @(negedge clk);
      out_ready = !(t >= 8 && t < 13);
      a = $urandom; b = $urandom;
      c_in = 1'($urandom_range(0, 1));
      sub  = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      #1;
      if (!out_ready) begin
        chk("stall_in_ready", 66'(in_ready), 66'd0);
        if (t == 8) begin
          held = {out_valid, sum, c_out, overflow};
          chk("stall_out_valid", 66'(out_valid), 66'd1);
        end else begin
          chk("stall_hold", 66'({out_valid, sum, c_out, overflow}),
              66'(held));
        end
      end
      if (in_ready) begin
        q0.push_back(model(32, {32'h0, a}, {32'h0, b}, c_in, sub));
        sent++;
      end
      t++;
    end
    chk("bp_sent", 66'(sent), 66'd16);
    drain0();

    // Async reset with three beats in flight.
    put(32'h1, 32'h2, 1'b0, 1'b0);
    put(32'h3, 32'h4, 1'b0, 1'b0);
    put(32'h5, 32'h6, 1'b0, 1'b0);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("pre_reset_valid", 66'(out_valid), 66'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", {64'(out_valid), in_ready, 1'b0},
        {64'd0, 1'b1, 1'b0});
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    vcnt = 0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (out_valid) vcnt++;
    end
    chk("no_beats_after_reset", 66'(vcnt), 66'd0);
    put(32'h8000_0000, 32'h1, 1'b0, 1'b1);
    q0.push_back(mk(32'h7FFF_FFFF, 1'b1, 1'b1));
    drain0();

    n = 0;
    while (!(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done &&
             g_rnd[3].done) && n < 40000) begin
      @(negedge clk);
      n++;
    end
    chk("random_done", 66'(n < 40000), 66'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
